// File: rtl/mem_stage_pkg.sv
// Shared codes for the MEM stage: memory/control opcodes, exception codes,
// bus widths, strobe polarities and the MEM pipeline register layout.
package mem_stage_pkg;

    localparam int WORD_ADDR_W = 30;
    localparam int WORD_DATA_W = 32;
    localparam int REG_ADDR_W  = 5;

    localparam logic ENABLE   = 1'b1;
    localparam logic DISABLE  = 1'b0;
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;
    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;

    typedef enum logic [1:0] {
        MEM_OP_NOP = 2'd0,
        MEM_OP_LDW = 2'd1,
        MEM_OP_STW = 2'd2,
        MEM_OP_RSV = 2'd3
    } mem_op_t;

    typedef enum logic [1:0] {
        CTRL_OP_NOP  = 2'd0,
        CTRL_OP_WRCR = 2'd1,
        CTRL_OP_EXRT = 2'd2,
        CTRL_OP_RSV  = 2'd3
    } ctrl_op_t;

    typedef enum logic [2:0] {
        ISA_EXP_NO_EXP     = 3'd0,
        ISA_EXP_EXT_INT    = 3'd1,
        ISA_EXP_UNDEF_INSN = 3'd2,
        ISA_EXP_OVERFLOW   = 3'd3,
        ISA_EXP_MISS_ALIGN = 3'd4,
        ISA_EXP_TRAP       = 3'd5,
        ISA_EXP_PRV_VIO    = 3'd6,
        ISA_EXP_RSV        = 3'd7
    } isa_exp_t;

    typedef struct packed {
        logic [WORD_ADDR_W-1:0] pc;
        logic                   en;
        logic                   br_flag;
        logic [1:0]             ctrl_op;
        logic [REG_ADDR_W-1:0]  dst_addr;
        logic                   gpr_we_;
        logic [2:0]             exp_code;
        logic [WORD_DATA_W-1:0] out;
        logic                   cp2_fs_0;
        logic                   cp2_ts_0;
        logic                   cp2_as_0;
        logic [WORD_DATA_W-1:0] cp2_wr_data;
    } mem_reg_t;

    localparam mem_reg_t MEM_REG_RST = '{
        pc: '0, en: DISABLE, br_flag: 1'b0, ctrl_op: CTRL_OP_NOP,
        dst_addr: '0, gpr_we_: DISABLE_, exp_code: ISA_EXP_NO_EXP, out: '0,
        cp2_fs_0: 1'b0, cp2_ts_0: 1'b0, cp2_as_0: 1'b0, cp2_wr_data: '0
    };

    function automatic logic is_mem_access(input logic [1:0] op);
        return (op == MEM_OP_LDW) || (op == MEM_OP_STW);
    endfunction

endpackage

// File: rtl/mem_bus_if.sv
// Purpose: bus master FSM (IDLE/REQ/ACCESS/STALL) for one LDW/STW word access.
// Latency: load data valid combinationally in the bus_rdy_ cycle, buffered while stalled.
// Backpressure: busy held until bus_rdy_; completion under stall parks in STALL.
module mem_bus_if
    import mem_stage_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   req,
    input  logic                   rw,
    input  logic [WORD_ADDR_W-1:0] addr,
    input  logic [WORD_DATA_W-1:0] wr_data,
    output logic                   busy,
    output logic                   rd_vld,
    output logic [WORD_DATA_W-1:0] rd_data,
    output logic                   discard,
    output logic                   bus_req_,
    output logic [WORD_ADDR_W-1:0] bus_addr,
    output logic                   bus_as_,
    output logic                   bus_rw,
    output logic [WORD_DATA_W-1:0] bus_wr_data,
    input  logic                   bus_grnt_,
    input  logic                   bus_rdy_,
    input  logic [WORD_DATA_W-1:0] bus_rd_data
);

    typedef enum logic [1:0] {IDLE, REQ, ACCESS, STALL} state_t;

    state_t                 state, state_nxt;
    logic                   first_q;
    logic                   discard_q;
    logic                   active;
    logic [WORD_DATA_W-1:0] rd_buf;

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        rd_vld    = 1'b0;
        active    = 1'b0;
        bus_req_  = DISABLE_;
        bus_as_   = DISABLE_;
        case (state)
            IDLE: begin
                if (req && !flush && !reset) begin
                    bus_req_  = ENABLE_;
                    busy      = 1'b1;
                    active    = 1'b1;
                    state_nxt = (bus_grnt_ == ENABLE_) ? ACCESS : REQ;
                end
            end
            REQ: begin
                bus_req_ = ENABLE_;
                active   = 1'b1;
                if (flush) begin
                    state_nxt = IDLE;
                end else begin
                    busy = 1'b1;
                    if (bus_grnt_ == ENABLE_) state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                bus_req_ = ENABLE_;
                active   = 1'b1;
                bus_as_  = first_q ? ENABLE_ : DISABLE_;
                if (bus_rdy_ == ENABLE_) begin
                    rd_vld    = 1'b1;
                    state_nxt = stall ? STALL : IDLE;
                end else begin
                    busy = 1'b1;
                end
            end
            STALL: begin
                rd_vld = 1'b1;
                if (!stall) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Address/data only reach the bus while this stage owns (or asks for) it.
    assign bus_addr    = active ? addr    : '0;
    assign bus_wr_data = active ? wr_data : '0;
    assign bus_rw      = active ? rw      : READ;
    assign rd_data     = (state == STALL) ? rd_buf : bus_rd_data;
    assign discard     = discard_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            first_q   <= 1'b0;
            discard_q <= 1'b0;
            rd_buf    <= '0;
        end else begin
            state   <= state_nxt;
            first_q <= (state_nxt == ACCESS) && (state != ACCESS);
            // A flush seen mid-access must still drop the data when it finally lands.
            discard_q <= ((state == ACCESS) || (state == STALL)) &&
                         (state_nxt != IDLE) && (discard_q || flush);
            if ((state == ACCESS) && (bus_rdy_ == ENABLE_)) rd_buf <= bus_rd_data;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Purpose: MEM pipeline stage, bus access via mem_bus_if plus MEM output register (MEM_MISALIGN_CHK_EN enables misalignment traps).
// Latency: output register updates one clk after the access completes (0 cycles after bus_rdy_ on fwd_data).
// Backpressure: busy requests a pipeline stall; stall or busy holds every mem_* output.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WORD_ADDR_W-1:0] ex_pc,
    input  logic                   ex_en,
    input  logic                   ex_br_flag,
    input  logic [1:0]             ex_mem_op,
    input  logic [WORD_DATA_W-1:0] ex_mem_wr_data,
    input  logic [1:0]             ex_ctrl_op,
    input  logic [REG_ADDR_W-1:0]  ex_dst_addr,
    input  logic                   ex_gpr_we_,
    input  logic [2:0]             ex_exp_code,
    input  logic [WORD_DATA_W-1:0] ex_out,
    input  logic                   ex_cp2_fs_0,
    input  logic                   ex_cp2_ts_0,
    input  logic                   ex_cp2_as_0,
    input  logic [WORD_DATA_W-1:0] ex_cp2_wr_data,
    input  logic                   stall,
    input  logic                   flush,
    output logic                   busy,
    output logic                   bus_req_,
    output logic [WORD_ADDR_W-1:0] bus_addr,
    output logic                   bus_as_,
    output logic                   bus_rw,
    output logic [WORD_DATA_W-1:0] bus_wr_data,
    input  logic                   bus_grnt_,
    input  logic                   bus_rdy_,
    input  logic [WORD_DATA_W-1:0] bus_rd_data,
    output logic [WORD_ADDR_W-1:0] mem_pc,
    output logic                   mem_en,
    output logic                   mem_br_flag,
    output logic [1:0]             mem_ctrl_op,
    output logic [REG_ADDR_W-1:0]  mem_dst_addr,
    output logic                   mem_gpr_we_,
    output logic [2:0]             mem_exp_code,
    output logic [WORD_DATA_W-1:0] mem_out,
    output logic                   mem_cp2_fs_0,
    output logic                   mem_cp2_ts_0,
    output logic                   mem_cp2_as_0,
    output logic [WORD_DATA_W-1:0] mem_cp2_wr_data,
    output logic [WORD_DATA_W-1:0] fwd_data
);

    logic                   miss_align;
    logic                   access;
    logic                   is_load;
    logic                   rd_vld;
    logic                   discard;
    logic [WORD_DATA_W-1:0] rd_data;
    mem_reg_t               mem_q, mem_d;

`ifdef MEM_MISALIGN_CHK_EN
    assign miss_align = ex_en && is_mem_access(ex_mem_op) && (ex_out[1:0] != 2'b00);
`else
    assign miss_align = 1'b0;
`endif

    assign access  = ex_en && is_mem_access(ex_mem_op) && !miss_align;
    assign is_load = (ex_mem_op == MEM_OP_LDW);

    mem_bus_if u_bus_if (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flush       (flush),
        .req         (access),
        .rw          (is_load ? READ : WRITE),
        .addr        (ex_out[WORD_DATA_W-1:2]),
        .wr_data     (ex_mem_wr_data),
        .busy        (busy),
        .rd_vld      (rd_vld),
        .rd_data     (rd_data),
        .discard     (discard),
        .bus_req_    (bus_req_),
        .bus_addr    (bus_addr),
        .bus_as_     (bus_as_),
        .bus_rw      (bus_rw),
        .bus_wr_data (bus_wr_data),
        .bus_grnt_   (bus_grnt_),
        .bus_rdy_    (bus_rdy_),
        .bus_rd_data (bus_rd_data)
    );

    assign fwd_data = (is_load && rd_vld) ? rd_data : ex_out;

    always_comb begin
        mem_d = mem_q;
        if (!stall && !busy) begin
            if (flush || discard) begin
                mem_d = MEM_REG_RST;
            end else begin
                mem_d.pc          = ex_pc;
                mem_d.en          = ex_en;
                mem_d.br_flag     = ex_br_flag;
                mem_d.ctrl_op     = ex_ctrl_op;
                mem_d.dst_addr    = ex_dst_addr;
                mem_d.gpr_we_     = ex_gpr_we_;
                mem_d.exp_code    = ex_exp_code;
                mem_d.out         = fwd_data;
                mem_d.cp2_fs_0    = ex_cp2_fs_0;
                mem_d.cp2_ts_0    = ex_cp2_ts_0;
                mem_d.cp2_as_0    = ex_cp2_as_0;
                mem_d.cp2_wr_data = ex_cp2_wr_data;
                if (miss_align) begin
                    mem_d.gpr_we_     = DISABLE_;
                    mem_d.ctrl_op     = CTRL_OP_NOP;
                    mem_d.exp_code    = ISA_EXP_MISS_ALIGN;
                    mem_d.out         = '0;
                    mem_d.cp2_fs_0    = 1'b0;
                    mem_d.cp2_ts_0    = 1'b0;
                    mem_d.cp2_as_0    = 1'b0;
                    mem_d.cp2_wr_data = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) mem_q <= MEM_REG_RST;
        else       mem_q <= mem_d;
    end

    assign mem_pc          = mem_q.pc;
    assign mem_en          = mem_q.en;
    assign mem_br_flag     = mem_q.br_flag;
    assign mem_ctrl_op     = mem_q.ctrl_op;
    assign mem_dst_addr    = mem_q.dst_addr;
    assign mem_gpr_we_     = mem_q.gpr_we_;
    assign mem_exp_code    = mem_q.exp_code;
    assign mem_out         = mem_q.out;
    assign mem_cp2_fs_0    = mem_q.cp2_fs_0;
    assign mem_cp2_ts_0    = mem_q.cp2_ts_0;
    assign mem_cp2_as_0    = mem_q.cp2_as_0;
    assign mem_cp2_wr_data = mem_q.cp2_wr_data;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: transaction-level bus slave and pipeline
// controller, expected MEM register contents derived per instruction.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] ex_pc;
    logic        ex_en, ex_br_flag;
    logic [1:0]  ex_mem_op, ex_ctrl_op;
    logic [31:0] ex_mem_wr_data, ex_out, ex_cp2_wr_data;
    logic [4:0]  ex_dst_addr;
    logic        ex_gpr_we_;
    logic [2:0]  ex_exp_code;
    logic        ex_cp2_fs_0, ex_cp2_ts_0, ex_cp2_as_0;
    logic        stall, flush, busy;
    logic        bus_req_, bus_as_, bus_rw, bus_grnt_, bus_rdy_;
    logic [29:0] bus_addr;
    logic [31:0] bus_wr_data, bus_rd_data;
    logic [29:0] mem_pc;
    logic        mem_en, mem_br_flag, mem_gpr_we_;
    logic [1:0]  mem_ctrl_op;
    logic [4:0]  mem_dst_addr;
    logic [2:0]  mem_exp_code;
    logic [31:0] mem_out, mem_cp2_wr_data, fwd_data;
    logic        mem_cp2_fs_0, mem_cp2_ts_0, mem_cp2_as_0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .reset(reset),
        .ex_pc(ex_pc), .ex_en(ex_en), .ex_br_flag(ex_br_flag), .ex_mem_op(ex_mem_op),
        .ex_mem_wr_data(ex_mem_wr_data), .ex_ctrl_op(ex_ctrl_op), .ex_dst_addr(ex_dst_addr),
        .ex_gpr_we_(ex_gpr_we_), .ex_exp_code(ex_exp_code), .ex_out(ex_out),
        .ex_cp2_fs_0(ex_cp2_fs_0), .ex_cp2_ts_0(ex_cp2_ts_0), .ex_cp2_as_0(ex_cp2_as_0),
        .ex_cp2_wr_data(ex_cp2_wr_data), .stall(stall), .flush(flush), .busy(busy),
        .bus_req_(bus_req_), .bus_addr(bus_addr), .bus_as_(bus_as_), .bus_rw(bus_rw),
        .bus_wr_data(bus_wr_data), .bus_grnt_(bus_grnt_), .bus_rdy_(bus_rdy_),
        .bus_rd_data(bus_rd_data),
        .mem_pc(mem_pc), .mem_en(mem_en), .mem_br_flag(mem_br_flag), .mem_ctrl_op(mem_ctrl_op),
        .mem_dst_addr(mem_dst_addr), .mem_gpr_we_(mem_gpr_we_), .mem_exp_code(mem_exp_code),
        .mem_out(mem_out), .mem_cp2_fs_0(mem_cp2_fs_0), .mem_cp2_ts_0(mem_cp2_ts_0),
        .mem_cp2_as_0(mem_cp2_as_0), .mem_cp2_wr_data(mem_cp2_wr_data), .fwd_data(fwd_data)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic mem_reg_t obs_regs();
        mem_reg_t o;
        o.pc = mem_pc; o.en = mem_en; o.br_flag = mem_br_flag; o.ctrl_op = mem_ctrl_op;
        o.dst_addr = mem_dst_addr; o.gpr_we_ = mem_gpr_we_; o.exp_code = mem_exp_code;
        o.out = mem_out; o.cp2_fs_0 = mem_cp2_fs_0; o.cp2_ts_0 = mem_cp2_ts_0;
        o.cp2_as_0 = mem_cp2_as_0; o.cp2_wr_data = mem_cp2_wr_data;
        return o;
    endfunction

    function automatic mem_reg_t exp_clr();
        mem_reg_t e;
        e.pc = 30'd0; e.en = 1'b0; e.br_flag = 1'b0; e.ctrl_op = CTRL_OP_NOP;
        e.dst_addr = 5'd0; e.gpr_we_ = 1'b1; e.exp_code = ISA_EXP_NO_EXP; e.out = 32'd0;
        e.cp2_fs_0 = 1'b0; e.cp2_ts_0 = 1'b0; e.cp2_as_0 = 1'b0; e.cp2_wr_data = 32'd0;
        return e;
    endfunction

    function automatic mem_reg_t exp_copy(input logic [31:0] result);
        mem_reg_t e;
        e.pc = ex_pc; e.en = ex_en; e.br_flag = ex_br_flag; e.ctrl_op = ex_ctrl_op;
        e.dst_addr = ex_dst_addr; e.gpr_we_ = ex_gpr_we_; e.exp_code = ex_exp_code;
        e.out = result; e.cp2_fs_0 = ex_cp2_fs_0; e.cp2_ts_0 = ex_cp2_ts_0;
        e.cp2_as_0 = ex_cp2_as_0; e.cp2_wr_data = ex_cp2_wr_data;
        return e;
    endfunction

    function automatic mem_reg_t exp_misalign();
        mem_reg_t e;
        e = exp_clr();
        e.pc = ex_pc; e.en = ex_en; e.br_flag = ex_br_flag; e.dst_addr = ex_dst_addr;
        e.exp_code = ISA_EXP_MISS_ALIGN;
        return e;
    endfunction

    task automatic rand_ex(input logic [1:0] op, input logic [31:0] out);
        ex_pc = 30'($urandom); ex_en = 1'b1; ex_br_flag = 1'($urandom);
        ex_mem_op = op; ex_mem_wr_data = $urandom; ex_ctrl_op = 2'($urandom);
        ex_dst_addr = 5'($urandom); ex_gpr_we_ = 1'($urandom);
        ex_exp_code = 3'($urandom_range(0, 3)); ex_out = out;
        ex_cp2_fs_0 = 1'($urandom); ex_cp2_ts_0 = 1'($urandom);
        ex_cp2_as_0 = 1'($urandom); ex_cp2_wr_data = $urandom;
    endtask

    task automatic bubble();
        ex_en = 1'b0;
        ex_mem_op = MEM_OP_NOP;
    endtask

    // One aligned (or unchecked) bus access: grant g cycles after the request,
    // rdy_ after r further ACCESS cycles, stall held s cycles from completion,
    // optional one-cycle flush at cycle fl (fl < 0: none).
    task automatic run_mem(input int g, input int r, input int s, input int fl,
                           input logic [31:0] rdata);
        int          cc;
        int          busy_n;
        bit          is_ld;
        logic [31:0] result;
        mem_reg_t    exp;
        cc     = g + 1 + r;
        busy_n = 0;
        is_ld  = (ex_mem_op == MEM_OP_LDW);
        result = is_ld ? rdata : ex_out;
        exp    = (fl >= 0) ? exp_clr() : exp_copy(result);
        for (int c = 0; c <= cc + s; c++) begin
            bus_grnt_   = (c >= g && c <= cc) ? 1'b0 : 1'b1;
            bus_rdy_    = (c == cc) ? 1'b0 : 1'b1;
            bus_rd_data = (c == cc) ? rdata : $urandom;
            stall       = (c >= cc && c < cc + s);
            flush       = (c == fl);
            @(negedge clk);
            if (busy) busy_n++;
            if (c == 0) begin
                check("bus_req_", 128'(bus_req_), 128'(1'b0));
                check("bus_addr", 128'(bus_addr), 128'(ex_out[31:2]));
                check("bus_rw", 128'(bus_rw), 128'(is_ld));
                if (!is_ld) check("bus_wr_data", 128'(bus_wr_data), 128'(ex_mem_wr_data));
            end
            if (c == g + 1) check("bus_as_first", 128'(bus_as_), 128'(1'b0));
            if (c == g + 2 && c <= cc) check("bus_as_once", 128'(bus_as_), 128'(1'b1));
            if (c > cc) begin
                check("stall_bus_req_", 128'(bus_req_), 128'(1'b1));
                check("stall_busy", 128'(busy), 128'(1'b0));
            end
            if (c == cc + s && fl < 0) check("fwd_data", 128'(fwd_data), 128'(result));
            @(posedge clk); #1;
        end
        bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; stall = 1'b0; flush = 1'b0;
        check("busy_cycles", 128'(busy_n), 128'(g + 1 + r));
        bubble();
        @(negedge clk);
        check("mem_regs", 128'(obs_regs()), 128'(exp));
        if (fl < 0) check("mem_out", 128'(mem_out), 128'(result));
        @(posedge clk); #1;
    endtask

    task automatic run_plain(input int s);
        mem_reg_t exp;
        exp = exp_copy(ex_out);
        for (int c = 0; c <= s; c++) begin
            stall = (c < s);
            @(negedge clk);
            check("plain_busy", 128'(busy), 128'(1'b0));
            check("plain_bus_req_", 128'(bus_req_), 128'(1'b1));
            @(posedge clk); #1;
        end
        stall = 1'b0;
        bubble();
        @(negedge clk);
        check("plain_regs", 128'(obs_regs()), 128'(exp));
        @(posedge clk); #1;
    endtask

    task automatic run_misalign(input int s);
`ifdef MEM_MISALIGN_CHK_EN
        begin
            mem_reg_t exp;
            exp = exp_misalign();
            for (int c = 0; c <= s; c++) begin
                stall = (c < s);
                @(negedge clk);
                check("mis_bus_req_", 128'(bus_req_), 128'(1'b1));
                check("mis_busy", 128'(busy), 128'(1'b0));
                @(posedge clk); #1;
            end
            stall = 1'b0;
            bubble();
            @(negedge clk);
            check("mis_regs", 128'(obs_regs()), 128'(exp));
            @(posedge clk); #1;
        end
`else
        run_mem($urandom_range(0, 2), $urandom_range(0, 2), s, -1, $urandom);
`endif
    endtask

    task automatic run_flush_req();
        rand_ex(MEM_OP_LDW, 32'h0000_0440);
        bus_grnt_ = 1'b1;
        @(negedge clk);
        check("freq_req_", 128'(bus_req_), 128'(1'b0));
        check("freq_busy", 128'(busy), 128'(1'b1));
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        check("freq_req_held", 128'(bus_req_), 128'(1'b0));
        @(posedge clk); #1;
        flush = 1'b0;
        bubble();
        @(negedge clk);
        check("freq_req_drop", 128'(bus_req_), 128'(1'b1));
        check("freq_regs", 128'(obs_regs()), 128'(exp_clr()));
        @(posedge clk); #1;
    endtask

    task automatic run_reset_access();
        rand_ex(MEM_OP_LDW, 32'h0000_0800);
        bus_grnt_ = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_acc_as_", 128'(bus_as_), 128'(1'b0));
        @(posedge clk); #1;
        reset = 1'b1;
        bubble();
        bus_grnt_ = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_as_", 128'(bus_as_), 128'(1'b1));
        check("rst_req_", 128'(bus_req_), 128'(1'b1));
        check("rst_busy", 128'(busy), 128'(1'b0));
        check("rst_regs", 128'(obs_regs()), 128'(exp_clr()));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rv;
        int          k;
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; bus_rd_data = 32'd0;
        rand_ex(MEM_OP_NOP, 32'd0);
        bubble();
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_req_", 128'(bus_req_), 128'(1'b1));
        check("reset_as_", 128'(bus_as_), 128'(1'b1));
        check("reset_rw", 128'(bus_rw), 128'(1'b1));
        check("reset_addr", 128'(bus_addr), 128'(30'd0));
        check("reset_wr_data", 128'(bus_wr_data), 128'(32'd0));
        check("reset_busy", 128'(busy), 128'(1'b0));
        check("reset_regs", 128'(obs_regs()), 128'(exp_clr()));
        @(posedge clk); #1;
        reset = 1'b0;

        rand_ex(MEM_OP_LDW, 32'h0000_0100);
        run_mem(0, 2, 0, -1, 32'hDEAD_BEEF);

        rand_ex(MEM_OP_STW, 32'h0000_0204);
        ex_mem_wr_data = 32'h1234_5678;
        run_mem(3, 1, 0, -1, $urandom);

        rand_ex(MEM_OP_LDW, 32'h0000_03F0);
        run_mem(1, 1, 4, -1, 32'hCAFE_F00D);

        rand_ex(MEM_OP_LDW, 32'h0000_0102);
        run_misalign(0);

        run_flush_req();

        rand_ex(MEM_OP_LDW, 32'h0000_0080);
        run_mem(0, 3, 0, 2, $urandom);

        rand_ex(MEM_OP_NOP, 32'h0BAD_CAFE);
        run_plain(0);
        run_reset_access();

        for (int i = 0; i < 50; i++) begin
            k  = $urandom_range(0, 9);
            rv = $urandom;
            if (k < 3) begin
                rand_ex(2'($urandom), rv);
                if (k == 2 || is_mem_access(ex_mem_op)) ex_en = 1'b0;
                run_plain($urandom_range(0, 2));
            end else if (k < 8) begin
                rv[1:0] = 2'b00;
                rand_ex(($urandom_range(0, 1) == 0) ? MEM_OP_LDW : MEM_OP_STW, rv);
                run_mem($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                        -1, $urandom);
            end else if (k == 8) begin
                rv[1:0] = 2'($urandom_range(1, 3));
                rand_ex(($urandom_range(0, 1) == 0) ? MEM_OP_LDW : MEM_OP_STW, rv);
                run_misalign($urandom_range(0, 2));
            end else begin
                int g, r;
                g = $urandom_range(0, 2);
                r = $urandom_range(1, 3);
                rv[1:0] = 2'b00;
                rand_ex(MEM_OP_LDW, rv);
                run_mem(g, r, $urandom_range(0, 2), g + 1 + $urandom_range(0, r - 1), $urandom);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports: clk in 1 (system clock); reset in 1 (synchronous, active-high, sampled on rising clk).
REQ-002 SHALL have inputs ex_pc 30, ex_en 1, ex_br_flag 1, ex_mem_op 2, ex_mem_wr_data 32, ex_ctrl_op 2, ex_dst_addr 5, ex_gpr_we_ 1, ex_exp_code 3, ex_out 32: the EX pipeline register contents.
REQ-003 SHALL have inputs ex_cp2_fs_0 1, ex_cp2_ts_0 1, ex_cp2_as_0 1, ex_cp2_wr_data 32: coprocessor-2 controls and data.
REQ-004 SHALL have inputs stall 1 and flush 1 from the pipeline controller, and output busy 1 (memory-access stall request).
REQ-005 SHALL have bus outputs bus_req_ 1, bus_addr 30, bus_as_ 1, bus_rw 1 (1=read), bus_wr_data 32, and bus inputs bus_grnt_ 1, bus_rdy_ 1, bus_rd_data 32.
REQ-006 SHALL have outputs mem_pc 30, mem_en 1, mem_br_flag 1, mem_ctrl_op 2, mem_dst_addr 5, mem_gpr_we_ 1, mem_exp_code 3, mem_out 32, mem_cp2_fs_0/ts_0/as_0 1 each, mem_cp2_wr_data 32.
REQ-007 SHALL output fwd_data 32: the combinational result of the current stage (load data or ex_out) for forwarding to ID.

Function
REQ-008 Access condition: ex_en=1 and ex_mem_op in {LDW, STW} and ex_out[1:0]=0; bus_addr=ex_out[31:2]; bus_wr_data=ex_mem_wr_data; bus_rw=1 for LDW, 0 for STW.
REQ-009 The bus FSM SHALL have states IDLE, REQ, ACCESS, STALL.
REQ-010 In IDLE: when the access condition holds and flush=0, assert bus_req_=0; go to ACCESS if bus_grnt_=0 in the same cycle, else to REQ.
REQ-011 In REQ: keep bus_req_=0; go to ACCESS on bus_grnt_=0.
REQ-012 In ACCESS: keep bus_req_=0 and bus_as_=0 for exactly the first ACCESS cycle; on bus_rdy_=0 release the bus, capture bus_rd_data into a read buffer, and go to STALL if stall=1, else to IDLE.
REQ-013 In STALL: bus released; return to IDLE when stall=0.
REQ-014 busy SHALL be 1 whenever an access is required and not yet completed (IDLE with request, REQ, ACCESS before bus_rdy_=0); busy=0 in the bus_rdy_=0 cycle and in STALL.
REQ-015 Load result SHALL be bus_rd_data in the completion cycle, the read buffer in STALL, and ex_out for non-load operations; latency is 0 cycles after bus_rdy_=0.
REQ-016 Misaligned LDW/STW (ex_out[1:0]!=0, ex_en=1): no bus request; output register loads mem_exp_code=MISS_ALIGN, mem_gpr_we_=1, mem_ctrl_op=NOP, mem_out=0, cp2 strobes 0.
REQ-017 Output register update priority when stall=0 and busy=0: flush clears all outputs to reset values; else exception per REQ-016; else copies ex_* (mem_out per REQ-015, mem_exp_code=ex_exp_code).
REQ-018 stall=1 or busy=1 SHALL hold all mem_* outputs.
REQ-019 flush during REQ SHALL drop the request and return to IDLE; flush during ACCESS SHALL complete the bus cycle and discard the data.

Reset
REQ-020 On reset=1 at a rising clk edge: FSM=IDLE; bus_req_=1, bus_as_=1, bus_rw=1, bus_addr=0, bus_wr_data=0; mem_pc=0, mem_en=0, mem_br_flag=0, mem_ctrl_op=NOP, mem_dst_addr=0, mem_gpr_we_=1, mem_exp_code=NOEXP, mem_out=0, cp2 outputs=0. Reset mid-access SHALL abandon the bus cycle.

Configuration
REQ-021 Macro MEM_MISALIGN_CHK_EN: defined -> REQ-016 applies; undefined -> ex_out[1:0] ignored, access always made at ex_out[31:2] and MISS_ALIGN never raised.

Structure
REQ-022 MEMOP/CTRLOP/ISAEXP codes, bus widths, ENABLE/DISABLE_ constants SHALL come from the shared package; FSM state encoding stays local.
REQ-023 One sub-module mem_bus_if SHALL hold the FSM (REQ-009..REQ-015); mem_stage holds the output register.

Verification
REQ-024 LDW ex_out=0x100, grant immediate, rdy_ low 2 cycles later, rd_data=0xDEADBEEF -> bus_addr=0x40, busy for 3 cycles, mem_out=0xDEADBEEF.
REQ-025 STW ex_out=0x204, ex_mem_wr_data=0x12345678, grant delayed 3 cycles -> bus_rw=0, wr_data=0x12345678, mem_out=0x204.
REQ-026 LDW ex_out=0x102 with macro defined -> no bus_req_, mem_exp_code=MISS_ALIGN, mem_gpr_we_=1; macro undefined -> access at 0x40.
REQ-027 LDW completes while stall=1 for 4 cycles -> FSM in STALL, mem_out=buffered data when stall drops.
REQ-028 flush asserted in REQ -> bus_req_ returns to 1 next cycle; all mem_* outputs at reset values.
REQ-029 reset asserted in ACCESS -> next cycle bus_as_=1, bus_req_=1, busy=0, outputs at reset values.
